chunked_add_sub: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock through a single CHUNK-bit full-adder slice, carrying between chunks in a register. It is the sequential, width-generic successor to the combinational 8-bit full adder. It trades latency for area, adds a subtract mode, signed overflow detection and a start/done handshake. It sits between operand registers and any consumer that tolerates WIDTH/CHUNK-cycle latency.

---
 rtl/chunked_add_sub.sv | 139 +++++++++++++
 1 files changed

// File: rtl/chunked_add_sub.sv
// ---------------------------------------------------------------------------
// chunked_add_sub
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed CHUNK
// bits per clock through one CHUNK-bit adder slice, and the carry between
// chunks is held in a register. An operation takes N = WIDTH/CHUNK RUN cycles
// and is followed by a single DONE cycle.
//
// Parameters:
//   WIDTH  operand/result width (a multiple of CHUNK, at least 2)
//   CHUNK  bits added per clock (1 = bit-serial, WIDTH = single cycle)
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled when not busy (IDLE or DONE)
//   A, B   operands, sampled with start
//   C_in   carry-in (add) / borrow-in (sub), sampled with start
//   sub    0: A+B+C_in, 1: A-B-C_in, sampled with start
//   busy   high while an operation is in RUN
//   done   one-cycle pulse when Sum/C_out/Ovf carry a new result
//   Sum    result modulo 2^WIDTH
//   C_out  final carry (in sub mode 1 = no borrow)
//   Ovf    two's-complement signed overflow
// ---------------------------------------------------------------------------
module chunked_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             Ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // low chunk feeds the adder, top fills with result
    logic [WIDTH-1:0] r_b;      // B already inverted for subtract
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK:0]   w_add;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_last;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    // One CHUNK-bit slice of the full adder.
    assign w_add = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};
    assign w_s   = w_add[CHUNK-1:0];
    assign w_c   = w_add[CHUNK];

    assign w_last = (r_cnt == CW'(N - 1));

    // Carry into the MSB recovered from the top sum bit: s = a ^ b ^ cin.
    // Only meaningful on the last chunk, where the slice MSB is the word MSB.
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_s[CHUNK-1];

    // A's consumed low bits are recycled: each result chunk is shifted into
    // the top, so after N shifts r_a holds the finished sum.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_a_next = w_s;
            assign w_b_next = '0;
        end else begin : g_multi
            assign w_a_next = {w_s, r_a[WIDTH-1:CHUNK]};
            assign w_b_next = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            C_out   <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        Sum     <= w_a_next;
                        C_out   <= w_c;
                        Ovf     <= w_msb_cin ^ w_c;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE accepting
                    // gives back-to-back operation with no idle gap.
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        // A - B - C_in == A + ~B + ~C_in
                        r_b     <= sub ? ~B : B;
                        r_carry <= C_in ^ sub;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
